// File: rtl/vga_mem_arbiter.sv
// Single-port memory arbiter between the CPU and the VGA glyph fetcher.
// VGA wins during active video, the CPU wins during blanking, and a wait counter bounds CPU stalls.
module vga_mem_arbiter #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned CPU_MAX_WAIT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vga_blank_n,
    input  logic                  vga_req,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    output logic                  vga_gnt,
    output logic [DATA_WIDTH-1:0] vga_data,
    output logic                  vga_valid,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [7:0] MaxWait = 8'(CPU_MAX_WAIT);

    typedef enum logic [1:0] {
        OwnNone,
        OwnVga,
        OwnCpu
    } owner_t;

    owner_t                owner_q;
    logic [7:0]            wait_cnt_q;
    logic [DATA_WIDTH-1:0] vga_data_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_q;

    logic force_cpu;
    logic cpu_win;
    logic vga_win;

    always_comb begin
        force_cpu = cpu_req && (wait_cnt_q == MaxWait);
        cpu_win   = cpu_req && (!vga_req || force_cpu || !vga_blank_n);
        vga_win   = vga_req && !cpu_win;
    end

    // Grants and the write strobe are masked so nothing leaks out while reset is held.
    always_comb begin
        vga_gnt   = vga_win && !reset;
        cpu_gnt   = cpu_win && !reset;
        mem_we    = cpu_win && cpu_we && !reset;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_win) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (vga_win) begin
            mem_addr = vga_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q     <= OwnNone;
            wait_cnt_q  <= 8'd0;
            vga_data_q  <= '0;
            cpu_rdata_q <= '0;
        end else begin
            if (vga_win) begin
                owner_q <= OwnVga;
            end else if (cpu_win && !cpu_we) begin
                owner_q <= OwnCpu;
            end else begin
                owner_q <= OwnNone;
            end

            if (cpu_win || !cpu_req) begin
                wait_cnt_q <= 8'd0;
            end else if (wait_cnt_q != MaxWait) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end

            if (owner_q == OwnVga) begin
                vga_data_q <= mem_rdata;
            end
            if (owner_q == OwnCpu) begin
                cpu_rdata_q <= mem_rdata;
            end
        end
    end

    // Read data is forwarded straight from the RAM in the return cycle, then held.
    always_comb begin
        vga_valid = (owner_q == OwnVga);
        cpu_valid = (owner_q == OwnCpu);
        vga_data  = vga_valid ? mem_rdata : vga_data_q;
        cpu_rdata = cpu_valid ? mem_rdata : cpu_rdata_q;
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: a reference arbitration/memory model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_vga_mem_arbiter;

    localparam int MAXW = 15;

    logic        clk;
    logic        reset;
    logic        vga_blank_n;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic        vga_gnt;
    logic [15:0] vga_data;
    logic        vga_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_gnt;
    logic [15:0] cpu_rdata;
    logic        cpu_valid;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    vga_mem_arbiter #(
        .DATA_WIDTH  (16),
        .ADDR_WIDTH  (16),
        .CPU_MAX_WAIT(MAXW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vga_blank_n(vga_blank_n),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_gnt    (vga_gnt),
        .vga_data   (vga_data),
        .vga_valid  (vga_valid),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rdata  (cpu_rdata),
        .cpu_valid  (cpu_valid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Synchronous block RAM seen by the DUT; contents reloaded while reset is high.
    logic [15:0] bram [1024];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) bram[i] <= 16'h5000 + 16'(i);
            bram[10'h040] <= 16'hBEEF;
        end else if (mem_we) begin
            bram[mem_addr[9:0]] <= mem_wdata;
        end
        mem_rdata <= bram[mem_addr[9:0]];
    end

    // Reference model: who should own each cycle, what the memory holds, and what returns next.
    logic [15:0] ref_mem [1024];
    int          m_wait;
    int          m_pend;
    logic [15:0] m_paddr;
    logic [15:0] m_vdata;
    logic [15:0] m_cdata;

    always @(negedge clk) begin
        logic        fc;
        logic        cw;
        logic        vw;
        logic [15:0] ea;
        logic [15:0] ewd;
        if (reset) begin
            chk("m_rst_vga_gnt", {31'd0, vga_gnt}, 32'd0);
            chk("m_rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
            chk("m_rst_mem_we", {31'd0, mem_we}, 32'd0);
            chk("m_rst_vga_valid", {31'd0, vga_valid}, 32'd0);
            chk("m_rst_cpu_valid", {31'd0, cpu_valid}, 32'd0);
            chk("m_rst_vga_data", {16'd0, vga_data}, 32'd0);
            chk("m_rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
            m_wait  = 0;
            m_pend  = 0;
            m_paddr = '0;
            m_vdata = '0;
            m_cdata = '0;
            for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h5000 + 16'(i);
            ref_mem[10'h040] = 16'hBEEF;
        end else begin
            fc = cpu_req && (m_wait == MAXW);
            cw = cpu_req && (!vga_req || fc || !vga_blank_n);
            vw = vga_req && !cw;
            if (m_pend == 1) m_vdata = ref_mem[m_paddr[9:0]];
            if (m_pend == 2) m_cdata = ref_mem[m_paddr[9:0]];
            ea  = cw ? cpu_addr : (vw ? vga_addr : 16'h0000);
            ewd = cw ? cpu_wdata : 16'h0000;
            chk("m_vga_gnt", {31'd0, vga_gnt}, {31'd0, vw});
            chk("m_cpu_gnt", {31'd0, cpu_gnt}, {31'd0, cw});
            chk("m_mem_we", {31'd0, mem_we}, {31'd0, cw && cpu_we});
            chk("m_mem_addr", {16'd0, mem_addr}, {16'd0, ea});
            chk("m_mem_wdata", {16'd0, mem_wdata}, {16'd0, ewd});
            chk("m_vga_valid", {31'd0, vga_valid}, {31'd0, m_pend == 1});
            chk("m_cpu_valid", {31'd0, cpu_valid}, {31'd0, m_pend == 2});
            chk("m_vga_data", {16'd0, vga_data}, {16'd0, m_vdata});
            chk("m_cpu_rdata", {16'd0, cpu_rdata}, {16'd0, m_cdata});
            if (cw && cpu_we) ref_mem[cpu_addr[9:0]] = cpu_wdata;
            m_pend  = vw ? 1 : ((cw && !cpu_we) ? 2 : 0);
            m_paddr = vw ? vga_addr : cpu_addr;
            if (cw || !cpu_req) m_wait = 0;
            else if (m_wait < MAXW) m_wait = m_wait + 1;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        vga_blank_n = 1'b1;
        vga_req     = 1'b1;
        cpu_req     = 1'b1;
        cpu_we      = 1'b0;
        vga_addr    = 16'h0040;
        cpu_addr    = 16'h0000;
        cpu_wdata   = 16'h0000;

        // Reset with both requesting: nothing granted.
        repeat (3) begin
            @(negedge clk);
            chk("rst_vga_gnt", {31'd0, vga_gnt}, 32'd0);
            chk("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
            chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("first_gnt_vga", {31'd0, vga_gnt}, 32'd1);
        chk("first_gnt_cpu", {31'd0, cpu_gnt}, 32'd0);
        chk("first_addr", {16'd0, mem_addr}, 32'h0040);

        // VGA read of 0x0040 returns 0xBEEF one cycle later, then holds.
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("vga_rd_valid", {31'd0, vga_valid}, 32'd1);
        chk("vga_rd_data", {16'd0, vga_data}, 32'h0000BEEF);
        next_cycle();
        vga_req = 1'b0;
        @(negedge clk);
        chk("vga_rd2_data", {16'd0, vga_data}, 32'h0000BEEF);
        next_cycle();
        @(negedge clk);
        chk("vga_idle_valid", {31'd0, vga_valid}, 32'd0);
        chk("vga_hold_data", {16'd0, vga_data}, 32'h0000BEEF);

        // Blanking: CPU write wins over VGA, then VGA reads the written word.
        next_cycle();
        vga_blank_n = 1'b0;
        vga_req     = 1'b1;
        vga_addr    = 16'h0100;
        cpu_req     = 1'b1;
        cpu_we      = 1'b1;
        cpu_addr    = 16'h0100;
        cpu_wdata   = 16'h1234;
        @(negedge clk);
        chk("blank_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
        chk("blank_vga_gnt", {31'd0, vga_gnt}, 32'd0);
        chk("blank_mem_we", {31'd0, mem_we}, 32'd1);
        chk("blank_mem_addr", {16'd0, mem_addr}, 32'h0100);
        next_cycle();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        @(negedge clk);
        chk("wr_nopulse", {31'd0, cpu_valid}, 32'd0);
        chk("rdback_gnt", {31'd0, vga_gnt}, 32'd1);
        next_cycle();
        vga_req = 1'b0;
        @(negedge clk);
        chk("rdback_data", {16'd0, vga_data}, 32'h00001234);

        // Priority follows vga_blank_n in the same cycle it changes.
        next_cycle();
        vga_blank_n = 1'b1;
        vga_req     = 1'b1;
        vga_addr    = 16'h0031;
        cpu_req     = 1'b1;
        cpu_addr    = 16'h0030;
        @(negedge clk);
        chk("edge_active_vga", {31'd0, vga_gnt}, 32'd1);
        next_cycle();
        vga_blank_n = 1'b0;
        @(negedge clk);
        chk("edge_blank_cpu", {31'd0, cpu_gnt}, 32'd1);
        next_cycle();
        vga_req = 1'b0;
        cpu_req = 1'b0;

        // Starvation guard: 15 VGA grants then one forced CPU grant, repeating.
        for (int k = 0; k < 32; k++) begin
            next_cycle();
            if (k == 0) begin
                vga_blank_n = 1'b1;
                vga_req     = 1'b1;
                cpu_req     = 1'b1;
            end
            @(negedge clk);
            chk("starve_cpu", {31'd0, cpu_gnt}, {31'd0, (k % 16) == 15});
            chk("starve_vga", {31'd0, vga_gnt}, {31'd0, (k % 16) != 15});
        end

        // Request withdrawn before grant leaves no wait credit behind.
        next_cycle();
        cpu_req = 1'b0;
        next_cycle();
        cpu_req = 1'b1;
        @(negedge clk);
        chk("withdraw_vga", {31'd0, vga_gnt}, 32'd1);
        next_cycle();
        vga_req = 1'b0;
        cpu_req = 1'b0;

        // Alternating owners: each read routed to its own requester.
        next_cycle();
        vga_req  = 1'b1;
        vga_addr = 16'h0010;
        @(negedge clk);
        chk("alt_vga_gnt", {31'd0, vga_gnt}, 32'd1);
        next_cycle();
        vga_req  = 1'b0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0020;
        @(negedge clk);
        chk("alt_vga_valid", {31'd0, vga_valid}, 32'd1);
        chk("alt_vga_data", {16'd0, vga_data}, 32'h00005010);
        chk("alt_cpu_valid0", {31'd0, cpu_valid}, 32'd0);
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("alt_cpu_valid", {31'd0, cpu_valid}, 32'd1);
        chk("alt_cpu_data", {16'd0, cpu_rdata}, 32'h00005020);
        chk("alt_vga_valid0", {31'd0, vga_valid}, 32'd0);

        // Reset right after a CPU read grant drops the pending return.
        next_cycle();
        cpu_req = 1'b1;
        @(negedge clk);
        chk("rstrd_gnt", {31'd0, cpu_gnt}, 32'd1);
        next_cycle();
        reset   = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rstrd_valid", {31'd0, cpu_valid}, 32'd0);
        chk("rstrd_data", {16'd0, cpu_rdata}, 32'd0);
        next_cycle();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_valid", {31'd0, cpu_valid}, 32'd0);
            chk("post_rst_data", {16'd0, cpu_rdata}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
